// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: opcodes and feeder state encoding shared by the systolic array and its feeder.
package sys_arr_pkg;
  localparam logic [2:0] OP_OS_FLOW  = 3'b100;
  localparam logic [2:0] OP_OS_DRAIN = 3'b110;
  localparam logic [2:0] OP_WS_FLOW  = 3'b000;
  localparam logic [2:0] OP_WS_LOAD  = 3'b001;
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_FLOW, ST_FLUSH, ST_DRAIN} feeder_state_e;
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: fixed-depth shift register, cleared by reset, used to skew one operand lane.
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;
  always_comb begin
    pipe_d[0] = d;
    for (int s = 1; s < DEPTH; s++) pipe_d[s] = pipe_q[s-1];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) pipe_q <= '0;
    else pipe_q <= pipe_d;
  assign q = pipe_q[DEPTH-1];
endmodule

// File: rtl/os_sys_arr_feeder.sv
// os_sys_arr_feeder: skews activation/weight vectors into an output-stationary array and
// sequences its clear, flow, flush and drain phases.
module os_sys_arr_feeder
  import sys_arr_pkg::*;
#(
  parameter int ACT_WIDTH    = 8,
  parameter int WGT_WIDTH    = 8,
  parameter int SYS_ARR_SIZE = 8,
  parameter int K_WIDTH      = 8,
  parameter int PE_LAT       = 2,
  parameter int DRAIN_LAT    = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [K_WIDTH-1:0]                  k_len,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ACT_WIDTH*SYS_ARR_SIZE-1:0]   act_vec,
  input  logic [WGT_WIDTH*SYS_ARR_SIZE-1:0]   wgt_vec,
  output logic [ACT_WIDTH*SYS_ARR_SIZE-1:0]   act_data_out,
  output logic [WGT_WIDTH*SYS_ARR_SIZE-1:0]   wgt_data_out,
  output logic [2:0]                          operation_signal_out,
  output logic                                sys_reset_out,
  output logic                                drain_valid,
  output logic [$clog2(SYS_ARR_SIZE)-1:0]     drain_row,
  output logic                                busy,
  output logic                                done
);
  localparam int N  = SYS_ARR_SIZE;
  localparam int RW = $clog2(SYS_ARR_SIZE);
  localparam int CW = (K_WIDTH > 16) ? K_WIDTH : 16;
  localparam logic [CW-1:0] FLUSH_END = CW'(2*(N-1) + PE_LAT - 1);
  localparam logic [CW-1:0] ROW_FIRST = CW'(DRAIN_LAT);
  localparam logic [CW-1:0] DONE_AT   = CW'(DRAIN_LAT + N);
  feeder_state_e state_q, state_d;
  logic [K_WIDTH-1:0] k_len_q, k_len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept;
  assign accept = state_q == ST_FLOW && in_valid;
  // cnt_q counts accepted vectors in FLOW and elapsed cycles in FLUSH/DRAIN
  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    cnt_d = cnt_q + CW'(1);
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start && k_len != '0) begin
          state_d = ST_CLEAR;
          k_len_d = k_len;
        end
      end
      ST_CLEAR: begin
        cnt_d = '0;
        state_d = ST_FLOW;
      end
      ST_FLOW: begin
        cnt_d = accept ? cnt_q + CW'(1) : cnt_q;
        if (accept && cnt_q == CW'(k_len_q) - CW'(1)) begin
          state_d = ST_FLUSH;
          cnt_d = '0;
        end
      end
      ST_FLUSH: if (cnt_q == FLUSH_END) begin
        state_d = ST_DRAIN;
        cnt_d = '0;
      end
      ST_DRAIN: if (cnt_q == DONE_AT) begin
        state_d = ST_IDLE;
        cnt_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= ST_IDLE;
      k_len_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      cnt_q <= cnt_d;
    end
  assign in_ready = state_q == ST_FLOW;
  assign busy = state_q != ST_IDLE;
  assign sys_reset_out = state_q == ST_CLEAR;
  assign operation_signal_out = state_q == ST_DRAIN ? OP_OS_DRAIN : OP_OS_FLOW;
  assign drain_valid = state_q == ST_DRAIN && cnt_q >= ROW_FIRST && cnt_q < DONE_AT;
  assign drain_row = drain_valid ? RW'(DONE_AT - CW'(1) - cnt_q) : '0;
  assign done = state_q == ST_DRAIN && cnt_q == DONE_AT;
  // lane i is delayed 1+i cycles; non-accepted cycles inject zeros so the skew never slips
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(.WIDTH(ACT_WIDTH), .DEPTH(1 + i)) u_act (
      .clk(clk),
      .reset(reset),
      .d(accept ? act_vec[i*ACT_WIDTH +: ACT_WIDTH] : '0),
      .q(act_data_out[i*ACT_WIDTH +: ACT_WIDTH])
    );
    skew_delay_line #(.WIDTH(WGT_WIDTH), .DEPTH(1 + i)) u_wgt (
      .clk(clk),
      .reset(reset),
      .d(accept ? wgt_vec[i*WGT_WIDTH +: WGT_WIDTH] : '0),
      .q(wgt_data_out[i*WGT_WIDTH +: WGT_WIDTH])
    );
  end
endmodule

// File: tb/tb_os_sys_arr_feeder.sv
// tb_os_sys_arr_feeder: drives tiles through the feeder, models an output-stationary array on its
// outputs, and scoreboards every drained row against the matrix product.
module tb_os_sys_arr_feeder;
  localparam int AW = 8, WW = 8, N = 8, KW = 8, PL = 2, DL = 2;
  localparam int HIST = 4096;
  logic clk = 0, reset = 0, start = 0, in_valid = 0;
  logic [KW-1:0] k_len = '0;
  logic [AW*N-1:0] act_vec = '0, act_data_out;
  logic [WW*N-1:0] wgt_vec = '0, wgt_data_out;
  logic [2:0] operation_signal_out, drain_row;
  logic in_ready, sys_reset_out, drain_valid, busy, done;
  always #5 clk = ~clk;
  os_sys_arr_feeder #(.ACT_WIDTH(AW), .WGT_WIDTH(WW), .SYS_ARR_SIZE(N), .K_WIDTH(KW),
                      .PE_LAT(PL), .DRAIN_LAT(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready), .act_vec(act_vec), .wgt_vec(wgt_vec), .act_data_out(act_data_out),
    .wgt_data_out(wgt_data_out), .operation_signal_out(operation_signal_out),
    .sys_reset_out(sys_reset_out), .drain_valid(drain_valid), .drain_row(drain_row),
    .busy(busy), .done(done)
  );
  typedef struct packed {
    logic [2:0] row;
    logic [N*32-1:0] vals;
  } exp_t;
  exp_t exp_q[$];
  int compared = 0, mismatched = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, first_dv = 0, done_cnt = 0;
  int a_m[N][16], w_m[16][N];
  int acc[N][N], ar[N][N], wr[N][N];
  int acc_t[16];
  int last_row0[N];
  logic [AW*N-1:0] hist_a[HIST];
  logic [WW*N-1:0] hist_w[HIST];
  int a_row0[7] = '{4, 1, 2, 3, 8, 9, 7};
  int w_col0[7] = '{1, 1, 7, 5, 5, 6, 5};
  int w_row0[8] = '{1, 6, 2, 4, 8, 4, 2, 6};
  int w_row1[8] = '{1, 55, 23, 59, 61, 18, 26, 28};
  int c_row0[8] = '{163, 137, 89, 133, 151, 92, 92, 110};
  always @(posedge clk) cyc <= cyc + 1;
  // array model fed from the DUT outputs; drained rows are popped from the scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic [N*32-1:0] got;
    int an, wn;
    if (cyc < HIST) begin
      hist_a[cyc] = act_data_out;
      hist_w[cyc] = wgt_data_out;
    end
    if (!reset || sys_reset_out) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] = 0; ar[i][j] = 0; wr[i][j] = 0;
        end
    end else begin
      for (int i = N - 1; i >= 0; i--)
        for (int j = N - 1; j >= 0; j--) begin
          an = (j == 0) ? int'(act_data_out[i*AW +: AW]) : ar[i][j-1];
          wn = (i == 0) ? int'(wgt_data_out[j*WW +: WW]) : wr[i-1][j];
          acc[i][j] += an * wn;
          ar[i][j] = an;
          wr[i][j] = wn;
        end
      if (drain_valid) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL drain_unexpected: row %0d drained, required no drain", drain_row);
        end else begin
          e = exp_q.pop_front();
          for (int j = 0; j < N; j++) got[j*32 +: 32] = acc[int'(drain_row)][j];
          if (drain_row !== e.row || got !== e.vals) begin
            mismatched++;
            $display("FAIL drain_row: got row %0d vals %h, required row %0d vals %h",
                     drain_row, got, e.row, e.vals);
          end
        end
        if (drain_row == 3'(N - 1)) first_dv = cyc;
        if (drain_row == 3'd0) for (int j = 0; j < N; j++) last_row0[j] = acc[0][j];
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        compared++;
        if (exp_q.size() != 0) begin
          mismatched++;
          $display("FAIL done_early: %0d rows still pending, required 0", exp_q.size());
        end
      end
    end
  end
  function automatic int base_lat(input int k);
    return 1 + k + 2*(N-1) + PL + DL + N + 1;
  endfunction
  task automatic push_golden(input int k);
    exp_t e;
    int s;
    for (int i = N - 1; i >= 0; i--) begin
      e.row = 3'(i);
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int q = 0; q < k; q++) s += a_m[i][q] * w_m[q][j];
        e.vals[j*32 +: 32] = s;
      end
      exp_q.push_back(e);
    end
  endtask
  task automatic fill_rand(input int k);
    for (int i = 0; i < N; i++)
      for (int q = 0; q < 16; q++) begin
        a_m[i][q] = (q < k) ? int'($urandom_range(0, 255)) : 0;
        w_m[q][i] = (q < k) ? int'($urandom_range(0, 255)) : 0;
      end
  endtask
  task automatic load_spec;
    for (int i = 0; i < N; i++)
      for (int q = 0; q < 16; q++) begin
        a_m[i][q] = (q < 7 && i < 6) ? ((i == 0) ? a_row0[q] : (i*7 + q*3 + 2) % 10) : 0;
        w_m[q][i] = (q >= 7) ? 0 : (q == 0) ? w_row0[i] : (q == 1) ? w_row1[i] : (i == 0) ? w_col0[q] : 2;
      end
    a_m[1][0] = 8;
  endtask
  task automatic run_tile(input int k, input int bubbles, input int abort_after);
    int got = 0, guard = 0, left = bubbles, d0 = done_cnt, g = 0;
    logic rdy;
    @(posedge clk); #1;
    push_golden(k);
    start = 1; k_len = KW'(k); start_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
    while (got < k && guard < 300) begin
      guard++;
      rdy = in_ready;
      in_valid = !(rdy && got == 3 && left > 0);
      if (rdy && !in_valid) left--;
      for (int i = 0; i < N; i++) begin
        act_vec[i*AW +: AW] = AW'(a_m[i][got]);
        wgt_vec[i*WW +: WW] = WW'(w_m[got][i]);
      end
      @(posedge clk); #1;
      if (rdy && in_valid) begin
        acc_t[got] = cyc - 1;
        got++;
      end
      if (abort_after > 0 && got == abort_after) break;
    end
    in_valid = 0; act_vec = '0; wgt_vec = '0;
    if (abort_after > 0) return;
    compared++;
    if (got != k || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL flow_end: accepted %0d in_ready %b, required %0d and 0", got, in_ready, k);
    end
    while (done_cnt == d0 && g < 300) begin @(posedge clk); g++; end
    #1;
    compared++;
    if (done_cnt == d0) begin
      mismatched++;
      $display("FAIL done_timeout: no done within %0d cycles, required one", g);
    end
    repeat (3) @(posedge clk); #1;
    compared++;
    if (done_cnt !== d0 + 1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL done_single: done count %0d busy %b, required %0d and 0", done_cnt - d0, busy, 1);
    end
  endtask
  task automatic test_reset;
    reset = 0; start = 1; k_len = 8'd5;
    repeat (3) @(posedge clk); #1;
    compared++;
    if (operation_signal_out !== 3'b100) begin
      mismatched++; $display("FAIL reset_opcode: got %b, required 100", operation_signal_out);
    end
    compared++;
    if (act_data_out !== '0 || wgt_data_out !== '0) begin
      mismatched++; $display("FAIL reset_data: got %h/%h, required 0", act_data_out, wgt_data_out);
    end
    compared++;
    if ({busy, in_ready, sys_reset_out, drain_valid, done, drain_row} !== '0) begin
      mismatched++;
      $display("FAIL reset_ctrl: busy %b rdy %b clr %b dv %b done %b row %0d, required all 0",
               busy, in_ready, sys_reset_out, drain_valid, done, drain_row);
    end
    start = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("FAIL reset_release: busy %b, required 0", busy);
    end
  endtask
  task automatic test_skew_e2e;
    int t0, bad = 0;
    load_spec();
    run_tile(7, 0, 0);
    t0 = acc_t[0];
    compared++;
    if (hist_a[t0][7:0] !== 8'd0 || hist_a[t0+1][7:0] !== 8'd4 || hist_w[t0+1][7:0] !== 8'd1) begin
      mismatched++;
      $display("FAIL skew_first: act0 %0d->%0d wgt0 %0d, required 0->4 and 1",
               hist_a[t0][7:0], hist_a[t0+1][7:0], hist_w[t0+1][7:0]);
    end
    compared++;
    if (hist_a[t0+2][15:0] !== {8'd8, 8'd1} || hist_w[t0+2][15:0] !== {8'd6, 8'd1}) begin
      mismatched++;
      $display("FAIL skew_second: act %h wgt %h, required 0801 and 0601",
               hist_a[t0+2][15:0], hist_w[t0+2][15:0]);
    end
    compared++;
    if (hist_w[t0+7][63:56] !== 8'd0 || hist_w[t0+8][63:56] !== 8'd6) begin
      mismatched++;
      $display("FAIL skew_lane7: got %0d then %0d, required 0 then 6", hist_w[t0+7][63:56], hist_w[t0+8][63:56]);
    end
    for (int q = 0; q < 7; q++)
      for (int i = 0; i < N; i++)
        if (int'(hist_a[acc_t[q]+1+i][i*AW +: AW]) != a_m[i][q] ||
            int'(hist_w[acc_t[q]+1+i][i*WW +: WW]) != w_m[q][i]) bad++;
    compared++;
    if (bad != 0) begin
      mismatched++; $display("FAIL skew_all: %0d misplaced lane samples, required 0", bad);
    end
    compared++;
    if (done_cyc - start_cyc != base_lat(7)) begin
      mismatched++;
      $display("FAIL latency: got %0d cycles, required %0d", done_cyc - start_cyc, base_lat(7));
    end
    compared++;
    if (done_cyc - first_dv != N) begin
      mismatched++; $display("FAIL drain_span: got %0d, required %0d", done_cyc - first_dv, N);
    end
    for (int j = 0; j < N; j++) if (last_row0[j] != c_row0[j]) bad++;
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL row0_golden: got %0d %0d %0d %0d, required 163 137 89 133",
               last_row0[0], last_row0[1], last_row0[2], last_row0[3]);
    end
  endtask
  task automatic test_bubbles;
    load_spec();
    run_tile(7, 2, 0);
    compared++;
    if (done_cyc - start_cyc != base_lat(7) + 2) begin
      mismatched++;
      $display("FAIL bubble_latency: got %0d cycles, required %0d", done_cyc - start_cyc, base_lat(7) + 2);
    end
  endtask
  task automatic test_boundaries;
    int d0;
    @(posedge clk); #1;
    start = 1; k_len = 8'd0;
    @(posedge clk); #1;
    start = 0;
    compared++;
    if (busy !== 1'b0 || sys_reset_out !== 1'b0) begin
      mismatched++; $display("FAIL k_zero: busy %b clr %b, required 0 and 0", busy, sys_reset_out);
    end
    fill_rand(5);
    fork
      run_tile(5, 0, 0);
      begin
        int g = 0;
        while (!drain_valid && g < 300) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        start = 1; k_len = 8'd5;
        repeat (3) @(posedge clk); #1;
        start = 0;
      end
    join
    d0 = done_cnt;
    repeat (5) @(posedge clk); #1;
    compared++;
    if (busy !== 1'b0 || done_cnt != d0) begin
      mismatched++; $display("FAIL start_in_drain: busy %b, required 0", busy);
    end
    fill_rand(1);
    run_tile(1, 0, 0);
    compared++;
    if (done_cyc - start_cyc != base_lat(1)) begin
      mismatched++;
      $display("FAIL k_one_latency: got %0d, required %0d", done_cyc - start_cyc, base_lat(1));
    end
  endtask
  task automatic test_reset_mid_flow;
    int d0;
    fill_rand(6);
    run_tile(6, 0, 3);
    reset = 0;
    #1;
    exp_q.delete();
    d0 = done_cnt;
    compared++;
    if (operation_signal_out !== 3'b100 || act_data_out !== '0 || wgt_data_out !== '0 ||
        {busy, in_ready, sys_reset_out, drain_valid, done} !== '0) begin
      mismatched++;
      $display("FAIL abort_outputs: op %b busy %b rdy %b data %h, required 100 0 0 0",
               operation_signal_out, busy, in_ready, act_data_out);
    end
    repeat (2) @(posedge clk); #1;
    reset = 1;
    repeat (60) @(posedge clk); #1;
    compared++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL abort_no_done: %0d done pulses busy %b, required 0 and 0", done_cnt - d0, busy);
    end
    fill_rand(4);
    run_tile(4, 0, 0);
  endtask
  initial begin
    test_reset();
    test_skew_e2e();
    test_bubbles();
    test_boundaries();
    test_reset_mid_flow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: run exceeded time limit, required completion");
    $fatal(1);
  end
endmodule

// File: doc/os_sys_arr_feeder.md
# os_sys_arr_feeder

Input-side controller for the output-stationary systolic array (`sys_arr`). It accepts one unskewed activation column vector and one weight row vector per reduction step k. It applies the diagonal skew required by the array and drives `operation_signal_in` through flow and drain. It also flags the cycles on which `final_result_out` carries a valid drained row. It sits between the operand buffers and `sys_arr`, replacing the hand-skewed stimulus used in bring-up benches.

## Interface
- ACT_WIDTH, 8, activation lane width
- WGT_WIDTH, 8, weight lane width
- SYS_ARR_SIZE, 8, array dimension N (lanes)
- K_WIDTH, 8, width of reduction-length field
- PE_LAT, 2, cycles from a PE's last operand arrival to its accumulator being final
- DRAIN_LAT, 2, cycles from drain opcode to first valid row on `final_result_out`

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a tile; sampled only in IDLE
- k_len  in  K_WIDTH  number of reduction steps K, captured on accepted start
- in_valid  in  1  operand vectors valid
- in_ready  out  1  feeder accepts vectors (high only in FLOW)
- act_vec  in  ACT_WIDTH*N  lane i = A[i][k]
- wgt_vec  in  WGT_WIDTH*N  lane j = W[k][j]
- act_data_out  out  ACT_WIDTH*N  skewed activations to `sys_arr`
- wgt_data_out  out  WGT_WIDTH*N  skewed weights to `sys_arr`
- operation_signal_out  out  3  opcode to `sys_arr`
- sys_reset_out  out  1  one-cycle accumulator clear to `sys_arr`
- drain_valid  out  1  `final_result_out` holds a valid row this cycle
- drain_row  out  $clog2(N)  PE row index of that output
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last drained row

## Operation
- States: IDLE → CLEAR → FLOW → FLUSH → DRAIN → IDLE.
- IDLE:
  - start=1 with k_len≠0 → CLEAR, capturing K.
  - start with k_len=0 is ignored.
- CLEAR: one cycle, sys_reset_out=1, opcode 3'b100 → FLOW.
- FLOW:
  - in_ready=1.
  - Each in_valid cycle accepts a vector pair and increments the k counter.
  - An in_valid=0 cycle injects an all-zero pair (bubble). Bubbles keep the skew aligned and contribute 0 to every accumulator.
  - After K vectors are accepted → FLUSH.
- FLUSH: zero vectors are injected for 2*(N-1)+PE_LAT cycles, then → DRAIN.
- DRAIN:
  - Opcode 3'b110.
  - drain_valid rises DRAIN_LAT cycles after entry and stays high N consecutive cycles.
  - drain_row counts N-1 down to 0.
  - done pulses on the cycle after drain_row=0, then → IDLE.
- Skew:
  - Lane i of act and wgt passes through a delay of 1+i registers.
  - Lane 0 sees vector k one cycle after acceptance; lane N-1 sees it N cycles after acceptance.
- Opcode is 3'b100 in every state except DRAIN.
- Reset:
  - All outputs are 0, except operation_signal_out = 3'b100.
  - All delay registers are cleared and state = IDLE.
  - Reset mid-tile aborts the tile with no done.
- start asserted while busy is ignored.

## Timing
- Accepted vector k appears on lane i at cycle t_k+1+i.
- FLOW lasts exactly K cycles if in_valid is held high; each low cycle extends FLOW by one.
- With an unstalled stream, cycles from start accept to done = 1 + K + 2(N-1) + PE_LAT + DRAIN_LAT + N + 1.
- in_ready is combinational from state only, never from in_valid.
- The skew pipeline is freely running: there is no stall input from `sys_arr`.

## Structure
- Package `sys_arr_pkg`:
  - opcode constants OP_OS_FLOW=3'b100, OP_OS_DRAIN=3'b110, OP_WS_FLOW=3'b000, OP_WS_LOAD=3'b001
  - feeder state enum
- One sub-module `skew_delay_line`: parameters WIDTH and DEPTH, zero-reset shift register. It is instantiated 2N times with DEPTH=1+i.

## Test plan
- **Reset:** hold reset=0 with start=1 → opcode=3'b100, all data 0, busy=0, no in_ready.
- **Skew, unstalled, 6×7×8:**
  - Stimulus: A padded to 8 rows, A row0=[4,1,2,3,8,9,7], W row0=[1,6,2,4,8,4,2,6], K=7, in_valid held.
  - First non-zero cycle: act lane0=4, wgt lane0=1.
  - Next cycle: act={1,8,…}, wgt={1,6,…}.
  - wgt lane7=6 first appears 7 cycles after lane0=1.
- **End-to-end with `sys_arr` model:** same matrices → drained rows match the golden product, e.g. row0=[163,137,89,133,151,92,92,110]. drain_valid is high for 8 cycles and done is a single pulse.
- **Bubbles:** deassert in_valid for 2 cycles mid-stream → identical drained results, done delayed exactly 2 cycles.
- **Boundaries:**
  - k_len=0 start → no state change.
  - start during DRAIN → ignored.
  - K=1 → correct outer product.
- **Reset mid-FLOW:** after 3 accepted vectors → outputs return to reset values, no done. A fresh tile afterwards is correct.
